// File: rtl/sect409k1_pkg.sv
// Shared constants and state type for the sect409k1 point encoder.
package sect409k1_pkg;

  localparam int unsigned FLEN   = 409;
  localparam int unsigned FBYTES = (FLEN + 7) / 8;

  localparam logic [7:0] PC_UNCOMP = 8'h04;
  localparam logic [7:0] PC_INF    = 8'h00;

  typedef enum logic [1:0] {IDLE, HDR, BODY, INF} enc_state_t;

endpackage

// File: rtl/sect409k1_pt_encode.sv
// SEC1 octet-string encoder for an affine sect409k1 point.
// Output is 0x04 || X || Y (big-endian coordinates), or a single 0x00 for infinity.
module sect409k1_pt_encode
  import sect409k1_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FLEN-1:0] x,
  input  logic [FLEN-1:0] y,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [7:0]      m_data,
  output logic            m_last
);

  localparam int unsigned PAD      = 8 * FBYTES - FLEN;
  localparam int unsigned SR_W     = 16 * FBYTES;
  localparam int unsigned CNT_LAST = 2 * FBYTES - 1;

  enc_state_t      state, state_next;
  logic [SR_W-1:0] shift_reg;
  logic [6:0]      cnt;
  logic            capture;
  logic            advance;

  // Next-state and output decode; outputs depend on state only so they hold while stalled.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_last     = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture    = 1'b1;
          state_next = ((x == '0) && (y == '0)) ? INF : HDR;
        end
      end
      INF: begin
        m_valid = 1'b1;
        m_data  = PC_INF;
        m_last  = 1'b1;
        if (m_ready) state_next = IDLE;
      end
      HDR: begin
        m_valid = 1'b1;
        m_data  = PC_UNCOMP;
        if (m_ready) state_next = BODY;
      end
      BODY: begin
        m_valid = 1'b1;
        m_data  = shift_reg[SR_W-1 -: 8];
        m_last  = (cnt == 7'(CNT_LAST));
        if (m_ready) begin
          advance = 1'b1;
          if (m_last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, coordinate shift register and body byte counter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_reg <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        // Each coordinate is zero-extended to a whole number of bytes so the MSB byte is {7'b0, msb}.
        shift_reg <= {{PAD{1'b0}}, x, {PAD{1'b0}}, y};
        cnt       <= '0;
      end else if (advance) begin
        shift_reg <= {shift_reg[SR_W-9:0], 8'h00};
        cnt       <= m_last ? '0 : cnt + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_sect409k1_pt_encode.sv
// Self-checking bench for sect409k1_pt_encode against a byte-queue reference model.
module tb_sect409k1_pt_encode;

  logic         clk = 1'b0;
  logic         rst, clr, in_valid, in_ready;
  logic [408:0] x, y;
  logic         m_valid, m_ready, m_last;
  logic [7:0]   m_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_d[$];
  logic [7:0] got_d[$];
  logic       got_l[$];
  int         stall_viol, rdy_viol, first_valid, cycles_used;
  bit         timed_out;

  always #5 clk = ~clk;

  sect409k1_pt_encode dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  function automatic logic [408:0] rand_fe();
    logic [415:0] t;
    for (int i = 0; i < 13; i++) t[32*i +: 32] = $urandom;
    return t[408:0];
  endfunction

  // Reference: SEC1 octet string from the coordinate values.
  function automatic void build_ref(input logic [408:0] px, input logic [408:0] py);
    logic [415:0] xe, ye;
    exp_d.delete();
    if (px == '0 && py == '0) begin
      exp_d.push_back(8'h00);
    end else begin
      xe = {7'b0, px};
      ye = {7'b0, py};
      exp_d.push_back(8'h04);
      for (int i = 51; i >= 0; i--) exp_d.push_back(xe[8*i +: 8]);
      for (int i = 51; i >= 0; i--) exp_d.push_back(ye[8*i +: 8]);
    end
  endfunction

  // Present one point at a negedge; returns at the following negedge.
  task automatic send_point(input logic [408:0] px, input logic [408:0] py);
    int w = 0;
    while (in_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) timed_out = 1;
    in_valid = 1'b1; x = px; y = py;
    @(negedge clk);
    in_valid = 1'b0; x = rand_fe(); y = rand_fe();
  endtask

  // Drive m_ready and record accepted beats; optionally pulse in_valid or clr mid-stream.
  task automatic collect(input int ready_pct, input int clr_after, input bit pulse);
    bit stalled = 0;
    logic [7:0] sd = '0;
    logic sl = 1'b0;
    int beats = 0;
    got_d.delete(); got_l.delete();
    stall_viol = 0; rdy_viol = 0; first_valid = -1; cycles_used = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (stalled && (m_valid !== 1'b1 || m_data !== sd || m_last !== sl)) stall_viol++;
      if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (in_ready !== 1'b0) rdy_viol++;
      if (pulse && cyc == 20) begin
        in_valid = 1'b1; x = rand_fe(); y = rand_fe();
      end else begin
        in_valid = 1'b0;
      end
      if (clr_after > 0 && beats == clr_after) begin
        m_ready = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; cycles_used = cyc + 1;
        return;
      end
      m_ready = ($urandom_range(99) < ready_pct);
      if (m_valid === 1'b1 && m_ready) begin
        got_d.push_back(m_data); got_l.push_back(m_last);
        beats++; stalled = 0;
        if (m_last === 1'b1) begin
          @(negedge clk);
          m_ready = 1'b0; in_valid = 1'b0; cycles_used = cyc + 1;
          return;
        end
      end else begin
        stalled = (m_valid === 1'b1); sd = m_data; sl = m_last;
      end
      @(negedge clk);
    end
    timed_out = 1; m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    n_cmp++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
    n_cmp++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_x1_y2();
    timed_out = 0;
    build_ref(409'd1, 409'd2);
    send_point(409'd1, 409'd2);
    collect(100, 0, 0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL x1y2_timeout got=1 exp=0"); end
    n_cmp++; if (got_d.size() != 105) begin n_fail++; $display("FAIL x1y2_len got=%0d exp=105", got_d.size()); end
    n_cmp++; if (first_valid != 0) begin n_fail++; $display("FAIL x1y2_latency got=%0d exp=0", first_valid); end
    n_cmp++; if (cycles_used != 105) begin n_fail++; $display("FAIL x1y2_cycles got=%0d exp=105", cycles_used); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1)) begin
        n_fail++; $display("FAIL x1y2_beat%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], i == exp_d.size() - 1);
      end
    end
    if (got_d.size() == 105) begin
      n_cmp++; if (got_d[52] !== 8'h01 || got_d[104] !== 8'h02) begin n_fail++; $display("FAIL x1y2_lsb got=%h,%h exp=01,02", got_d[52], got_d[104]); end
    end
    n_cmp++; if (rdy_viol != 0) begin n_fail++; $display("FAIL x1y2_in_ready_busy got=%0d exp=0", rdy_viol); end
    n_cmp++; if (in_ready !== 1'b1 || m_valid !== 1'b0) begin n_fail++; $display("FAIL x1y2_idle_after got=%b%b exp=10", in_ready, m_valid); end
  endtask

  task automatic test_xmax();
    logic [408:0] xm = '1;
    timed_out = 0;
    build_ref(xm, '0);
    send_point(xm, '0);
    collect(100, 0, 0);
    n_cmp++; if (timed_out || got_d.size() != 105) begin n_fail++; $display("FAIL xmax_len got=%0d exp=105", got_d.size()); end
    if (got_d.size() >= 3) begin
      n_cmp++; if (got_d[1] !== 8'h01 || got_d[2] !== 8'hFF) begin n_fail++; $display("FAIL xmax_msb got=%h,%h exp=01,ff", got_d[1], got_d[2]); end
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1)) begin
        n_fail++; $display("FAIL xmax_beat%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], i == exp_d.size() - 1);
      end
    end
  endtask

  task automatic test_inf();
    timed_out = 0;
    send_point('0, '0);
    collect(100, 0, 0);
    n_cmp++; if (timed_out || got_d.size() != 1) begin n_fail++; $display("FAIL inf_len got=%0d exp=1", got_d.size()); end
    if (got_d.size() >= 1) begin
      n_cmp++; if (got_d[0] !== 8'h00 || got_l[0] !== 1'b1) begin n_fail++; $display("FAIL inf_beat got=%h/%b exp=00/1", got_d[0], got_l[0]); end
    end
    n_cmp++; if (in_ready !== 1'b1 || m_valid !== 1'b0) begin n_fail++; $display("FAIL inf_idle_after got=%b%b exp=10", in_ready, m_valid); end
  endtask

  task automatic test_backpressure();
    for (int p = 0; p < 5; p++) begin
      logic [408:0] px, py;
      px = rand_fe(); py = rand_fe();
      if (p == 4) begin px = '0; py = '0; end
      timed_out = 0;
      build_ref(px, py);
      send_point(px, py);
      collect(50, 0, p == 1);
      n_cmp++; if (timed_out || got_d.size() != exp_d.size()) begin n_fail++; $display("FAIL bp%0d_len got=%0d exp=%0d", p, got_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        n_cmp++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1)) begin
          n_fail++; $display("FAIL bp%0d_beat%0d got=%h/%b exp=%h/%b", p, i, got_d[i], got_l[i], exp_d[i], i == exp_d.size() - 1);
        end
      end
      n_cmp++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp%0d_stall_stable got=%0d exp=0", p, stall_viol); end
      @(negedge clk);
      n_cmp++; if (m_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp%0d_no_extra got=%b%b exp=01", p, m_valid, in_ready); end
    end
  endtask

  task automatic test_clr();
    logic [408:0] px, py;
    px = rand_fe(); py = rand_fe();
    timed_out = 0;
    build_ref(px, py);
    send_point(px, py);
    collect(100, 10, 0);
    n_cmp++; if (timed_out || got_d.size() != 10) begin n_fail++; $display("FAIL clr_partial_len got=%0d exp=10", got_d.size()); end
    for (int i = 0; i < 10 && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== 1'b0) begin
        n_fail++; $display("FAIL clr_partial_beat%0d got=%h/%b exp=%h/0", i, got_d[i], got_l[i], exp_d[i]);
      end
    end
    n_cmp++; if (m_valid !== 1'b0 || in_ready !== 1'b1 || m_last !== 1'b0) begin n_fail++; $display("FAIL clr_after got=%b%b%b exp=010", m_valid, in_ready, m_last); end
    build_ref(409'd1, 409'd2);
    send_point(409'd1, 409'd2);
    collect(100, 0, 0);
    n_cmp++; if (timed_out || got_d.size() != 105) begin n_fail++; $display("FAIL clr_restart_len got=%0d exp=105", got_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1)) begin
        n_fail++; $display("FAIL clr_restart_beat%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], i == exp_d.size() - 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; m_ready = 1'b0; x = '0; y = '0;
    @(negedge clk);
    test_reset();
    test_x1_y2();
    test_xmax();
    test_inf();
    test_backpressure();
    test_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
